// File: rtl/dis_wei_sparse_if.sv
// dis_wei_sparse_if: fetch control, GBF weight/flag read ports and PEC hand-off for dis_wei_sparse.
interface dis_wei_sparse_if #(
  parameter int NUM_PEC = 16,
  parameter int KERNEL_SIZE = 9,
  parameter int BLOCK_DEPTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WPR = 8,
  parameter int ADDR_WIDTH = 12
);
  localparam int FLG_W = KERNEL_SIZE * BLOCK_DEPTH;
  localparam int CNT_W = $clog2(FLG_W + 1);
  logic CTRLWEI_PlsFetch, CFG_Dense, CTRLWEI_GetWei;
  logic GBFWEI_Val, GBFWEI_EnRd;
  logic [ADDR_WIDTH-1:0] GBFWEI_AddrRd;
  logic [WPR*DATA_WIDTH-1:0] GBFWEI_DatRd;
  logic GBFFLGWEI_Val, GBFFLGWEI_EnRd;
  logic [ADDR_WIDTH-1:0] GBFFLGWEI_AddrRd;
  logic [FLG_W-1:0] GBFFLGWEI_DatRd;
  logic [NUM_PEC-1:0] DISWEIPEC_RdyWei, PECDISWEI_GetWei;
  logic [FLG_W*DATA_WIDTH-1:0] DISWEIPEC_Wei;
  logic [FLG_W-1:0] DISWEIPEC_FlgWei;
  logic [CNT_W-1:0] DISWEIPEC_NumWei;
  modport master (
    input CTRLWEI_PlsFetch, CFG_Dense, GBFWEI_Val, GBFWEI_DatRd, GBFFLGWEI_Val, GBFFLGWEI_DatRd, PECDISWEI_GetWei,
    output CTRLWEI_GetWei, GBFWEI_EnRd, GBFWEI_AddrRd, GBFFLGWEI_EnRd, GBFFLGWEI_AddrRd,
      DISWEIPEC_RdyWei, DISWEIPEC_Wei, DISWEIPEC_FlgWei, DISWEIPEC_NumWei
  );
  modport slave (
    output CTRLWEI_PlsFetch, CFG_Dense, GBFWEI_Val, GBFWEI_DatRd, GBFFLGWEI_Val, GBFFLGWEI_DatRd, PECDISWEI_GetWei,
    input CTRLWEI_GetWei, GBFWEI_EnRd, GBFWEI_AddrRd, GBFFLGWEI_EnRd, GBFFLGWEI_AddrRd,
      DISWEIPEC_RdyWei, DISWEIPEC_Wei, DISWEIPEC_FlgWei, DISWEIPEC_NumWei
  );
endinterface

// File: rtl/dis_wei_sparse.sv
// dis_wei_sparse: per PEC, reads a sparsity flag word, then packed nonzero weights, and hands both to that PEC.
module dis_wei_sparse #(
  parameter int NUM_PEC = 16,
  parameter int KERNEL_SIZE = 9,
  parameter int BLOCK_DEPTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WPR = 8,
  parameter int ADDR_WIDTH = 12
) (
  input logic clk,
  input logic rst_n,
  dis_wei_sparse_if.master bus
);
  localparam int FLG_W = KERNEL_SIZE * BLOCK_DEPTH;
  localparam int CNT_W = $clog2(FLG_W + 1);
  localparam int POS_W = $clog2(BLOCK_DEPTH + 1);
  localparam int PEC_W = NUM_PEC > 1 ? $clog2(NUM_PEC) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, FLG, DAT, WAIT} state_t;
  state_t state, nextState;
  logic dense, flgIss, rdPend, getWei;
  logic enFlg, enWei, flgCap, lastCap, pecGet, lastPec;
  logic [PEC_W-1:0] pecIdx;
  logic [ADDR_WIDTH-1:0] addrWei, addrFlg;
  logic [CNT_W-1:0] numWei, flgCnt, nWords, wIss, wCap;
  logic [POS_W-1:0] posCnt [KERNEL_SIZE];
  logic [FLG_W-1:0] flgSrc, flgWei;
  logic [FLG_W*DATA_WIDTH-1:0] wei;

  // Total nonzero count is built from the per-kernel-position counts.
  always_comb begin
    flgSrc = dense ? '1 : bus.GBFFLGWEI_DatRd;
    flgCnt = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      posCnt[k] = '0;
      for (int b = 0; b < BLOCK_DEPTH; b++) posCnt[k] = posCnt[k] + POS_W'(flgSrc[k*BLOCK_DEPTH+b]);
      flgCnt = flgCnt + CNT_W'(posCnt[k]);
    end
  end

  assign nWords = CNT_W'((32'(numWei) + WPR - 1) / WPR);
  assign lastPec = pecIdx == PEC_W'(NUM_PEC - 1);
  assign enFlg = state == FLG && !dense && !flgIss && bus.GBFFLGWEI_Val;
  assign flgCap = state == FLG && (dense || flgIss);
  assign enWei = state == DAT && wIss != nWords && bus.GBFWEI_Val;
  assign lastCap = rdPend && wCap == nWords - 1'b1;
  assign pecGet = state == WAIT && bus.PECDISWEI_GetWei[pecIdx];

  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = bus.CTRLWEI_PlsFetch ? CHECK : IDLE;
      CHECK: nextState = bus.GBFWEI_Val && (bus.GBFFLGWEI_Val || dense) ? FLG : CHECK;
      FLG: nextState = flgCap ? (flgCnt == '0 ? WAIT : DAT) : FLG;
      DAT: nextState = lastCap ? WAIT : DAT;
      WAIT: nextState = pecGet ? (lastPec ? IDLE : CHECK) : WAIT;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pecIdx <= '0;
      addrWei <= '0;
      addrFlg <= '0;
      numWei <= '0;
      wIss <= '0;
      wCap <= '0;
      flgWei <= '0;
      wei <= '0;
      dense <= 1'b0;
      flgIss <= 1'b0;
      rdPend <= 1'b0;
      getWei <= 1'b0;
    end else begin
      rdPend <= enWei;
      getWei <= pecGet && lastPec;
      if (enFlg) addrFlg <= addrFlg + 1'b1;
      if (enWei) addrWei <= addrWei + 1'b1;
      if (state == IDLE && bus.CTRLWEI_PlsFetch) dense <= bus.CFG_Dense;
      if (state == CHECK && nextState == FLG) begin
        flgWei <= '0;
        wei <= '0;
        numWei <= '0;
        flgIss <= 1'b0;
        wIss <= '0;
        wCap <= '0;
      end
      if (enFlg) flgIss <= 1'b1;
      if (flgCap) begin
        flgWei <= flgSrc;
        numWei <= flgCnt;
      end
      if (enWei) wIss <= wIss + 1'b1;
      // Word k lands in slots k*WPR.., lanes past the nonzero count are dropped.
      if (rdPend) begin
        wCap <= wCap + 1'b1;
        for (int s = 0; s < FLG_W; s++)
          if (CNT_W'(s / WPR) == wCap && CNT_W'(s) < numWei)
            wei[s*DATA_WIDTH +: DATA_WIDTH] <= bus.GBFWEI_DatRd[(s % WPR)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (pecGet) pecIdx <= lastPec ? '0 : pecIdx + 1'b1;
    end
  end

  assign bus.GBFFLGWEI_EnRd = enFlg;
  assign bus.GBFFLGWEI_AddrRd = addrFlg;
  assign bus.GBFWEI_EnRd = enWei;
  assign bus.GBFWEI_AddrRd = addrWei;
  assign bus.DISWEIPEC_RdyWei = state == WAIT ? NUM_PEC'(1) << pecIdx : '0;
  assign bus.DISWEIPEC_Wei = wei;
  assign bus.DISWEIPEC_FlgWei = flgWei;
  assign bus.DISWEIPEC_NumWei = numWei;
  assign bus.CTRLWEI_GetWei = getWei;
endmodule

// File: tb/tb_dis_wei_sparse.sv
// tb_dis_wei_sparse: random fetches against a queue-based reference model; a monitor pops and compares at each PEC hand-off.
module tb_dis_wei_sparse;
  localparam int NUM_PEC = 2, KS = 9, BD = 32, DW = 8, WPR = 8, AW = 12;
  localparam int FLG_W = KS * BD, CNT_W = $clog2(FLG_W + 1), DEPTH = 1 << AW;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dis_wei_sparse_if #(.NUM_PEC(NUM_PEC), .KERNEL_SIZE(KS), .BLOCK_DEPTH(BD), .DATA_WIDTH(DW), .WPR(WPR), .ADDR_WIDTH(AW)) bus();
  dis_wei_sparse #(.NUM_PEC(NUM_PEC), .KERNEL_SIZE(KS), .BLOCK_DEPTH(BD), .DATA_WIDTH(DW), .WPR(WPR), .ADDR_WIDTH(AW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [FLG_W-1:0] flg;
    int num;
    logic [FLG_W*DW-1:0] wei;
    int pec;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [WPR*DW-1:0] memWei [DEPTH];
  logic [FLG_W-1:0] memFlg [DEPTH];
  int errors = 0, checks = 0;
  int mwa = 0, mfa = 0, totalWa = 0;
  int seenWa = 0, seenFa = 0;
  int popCnt = 0, ackCnt = 0, lastAck = -1, getPulses = 0, pecDelay = 1;
  bit valRand = 1'b0, seenRdy = 1'b0, prevGet = 1'b0;
  logic rFe, rWe;
  logic [AW-1:0] rFa, rWa;
  int fd, wd;
  logic [DW-1:0] wAct, wExp;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // GBF model: read latency 1, garbage on the data bus when not read
  always @(posedge clk) begin
    rFe = bus.GBFFLGWEI_EnRd;
    rWe = bus.GBFWEI_EnRd;
    rFa = bus.GBFFLGWEI_AddrRd;
    rWa = bus.GBFWEI_AddrRd;
    #1;
    bus.GBFFLGWEI_DatRd = rFe ? memFlg[rFa] : '1;
    bus.GBFWEI_DatRd = rWe ? memWei[rWa] : {$urandom, $urandom};
  end

  always @(posedge clk) begin
    #1;
    bus.GBFWEI_Val = valRand ? ($urandom_range(3) != 0) : 1'b1;
    bus.GBFFLGWEI_Val = valRand ? ($urandom_range(2) != 0) : 1'b1;
  end

  // PEC side: never acks on the first ready cycle, sometimes pokes the wrong bit first
  always @(negedge clk) begin
    bus.PECDISWEI_GetWei = '0;
    if (rst_n && bus.DISWEIPEC_RdyWei != '0) begin
      if (pecDelay > 0) begin
        pecDelay--;
        if ($urandom_range(1) == 1) bus.PECDISWEI_GetWei = ~bus.DISWEIPEC_RdyWei;
      end else begin
        bus.PECDISWEI_GetWei = bus.DISWEIPEC_RdyWei;
        pecDelay = 1 + $urandom_range(3);
        ackCnt++;
        for (int p = 0; p < NUM_PEC; p++) if (bus.DISWEIPEC_RdyWei[p]) lastAck = p;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      seenWa = 0;
      seenFa = 0;
      seenRdy = 1'b0;
      prevGet = 1'b0;
    end else begin
      if (bus.GBFWEI_EnRd) begin
        chk(bus.GBFWEI_Val, "wei_en_without_val", 1, 0);
        chk(bus.GBFWEI_AddrRd == AW'(seenWa), "wei_addr", bus.GBFWEI_AddrRd, seenWa);
        seenWa = (seenWa + 1) % DEPTH;
      end
      if (bus.GBFFLGWEI_EnRd) begin
        chk(bus.GBFFLGWEI_Val, "flg_en_without_val", 1, 0);
        chk(bus.GBFFLGWEI_AddrRd == AW'(seenFa), "flg_addr", bus.GBFFLGWEI_AddrRd, seenFa);
        seenFa = (seenFa + 1) % DEPTH;
      end
      if (bus.DISWEIPEC_RdyWei != '0 && !seenRdy) begin
        seenRdy = 1'b1;
        chk(popCnt == ackCnt, "prev_not_acked", popCnt, ackCnt);
        if (q.size() == 0) chk(1'b0, "unexpected_rdy", bus.DISWEIPEC_RdyWei, 0);
        else begin
          me = q.pop_front();
          popCnt++;
          chk(bus.DISWEIPEC_RdyWei == NUM_PEC'(1) << me.pec, "rdy_onehot", bus.DISWEIPEC_RdyWei, 1 << me.pec);
          chk(bus.DISWEIPEC_NumWei == CNT_W'(me.num), "numwei", bus.DISWEIPEC_NumWei, me.num);
          fd = -1;
          for (int i = 0; i < FLG_W; i++) if (fd < 0 && bus.DISWEIPEC_FlgWei[i] !== me.flg[i]) fd = i;
          chk(fd < 0, $sformatf("flgwei_bit%0d_popcount", fd), $countones(bus.DISWEIPEC_FlgWei), $countones(me.flg));
          wd = -1;
          wAct = '0;
          wExp = '0;
          for (int s = 0; s < FLG_W; s++)
            if (wd < 0 && bus.DISWEIPEC_Wei[s*DW +: DW] !== me.wei[s*DW +: DW]) begin
              wd = s;
              wAct = bus.DISWEIPEC_Wei[s*DW +: DW];
              wExp = me.wei[s*DW +: DW];
            end
          chk(wd < 0, $sformatf("wei_slot%0d", wd), wAct, wExp);
        end
      end else if (bus.DISWEIPEC_RdyWei == '0) seenRdy = 1'b0;
      if (bus.CTRLWEI_GetWei) begin
        chk(lastAck == NUM_PEC - 1 && !prevGet, "ctrl_getwei", lastAck, NUM_PEC - 1);
        getPulses++;
      end
      prevGet = bus.CTRLWEI_GetWei;
    end
  end

  // mode 0 random density, 1 all zero, 2 0xFF in position 0, 3 exactly 13 flags
  task automatic fetch(input bit dn, input int mode);
    logic [FLG_W-1:0] f;
    logic [WPR*DW-1:0] w;
    exp_t e;
    int n, dens, start, fa0, wa0;
    fa0 = mfa;
    wa0 = mwa;
    for (int p = 0; p < NUM_PEC; p++) begin
      f = '0;
      dens = $urandom_range(100);
      case (mode)
        0: for (int i = 0; i < FLG_W; i++) f[i] = $urandom_range(99) < dens;
        2: f[7:0] = 8'hFF;
        3: while ($countones(f) < 13) f[$urandom_range(FLG_W - 1)] = 1'b1;
        default: f = '0;
      endcase
      if (dn) f = '1;
      else begin
        memFlg[mfa] = f;
        mfa = (mfa + 1) % DEPTH;
      end
      n = $countones(f);
      e.flg = f;
      e.num = n;
      e.pec = p;
      e.wei = '0;
      for (int k = 0; k * WPR < n; k++) begin
        w = {$urandom, $urandom};
        memWei[mwa] = w;
        mwa = (mwa + 1) % DEPTH;
        totalWa++;
        for (int l = 0; l < WPR; l++) if (k * WPR + l < n) e.wei[(k*WPR+l)*DW +: DW] = w[l*DW +: DW];
      end
      q.push_back(e);
    end
    start = getPulses;
    bus.CFG_Dense = dn;
    bus.CTRLWEI_PlsFetch = 1'b1;
    @(negedge clk);
    bus.CTRLWEI_PlsFetch = 1'b0;
    bus.CFG_Dense = 1'($urandom_range(1));
    for (int c = 0; c < 3000 && getPulses == start; c++) @(negedge clk);
    chk(getPulses == start + 1, "fetch_done", getPulses - start, 1);
    chk(seenWa == mwa, "wei_read_count", (seenWa - wa0 + DEPTH) % DEPTH, (mwa - wa0 + DEPTH) % DEPTH);
    chk(seenFa == mfa, "flg_read_count", (seenFa - fa0 + DEPTH) % DEPTH, (mfa - fa0 + DEPTH) % DEPTH);
  endtask

  task automatic chkIdle(input string tag);
    chk(bus.DISWEIPEC_Wei == '0, {tag, "_wei"}, $countones(bus.DISWEIPEC_Wei), 0);
    chk(bus.DISWEIPEC_FlgWei == '0, {tag, "_flgwei"}, $countones(bus.DISWEIPEC_FlgWei), 0);
    chk(bus.DISWEIPEC_NumWei == '0, {tag, "_numwei"}, bus.DISWEIPEC_NumWei, 0);
    chk({bus.GBFWEI_EnRd, bus.GBFFLGWEI_EnRd, bus.CTRLWEI_GetWei} == 3'b0, {tag, "_strobes"},
        {bus.GBFWEI_EnRd, bus.GBFFLGWEI_EnRd, bus.CTRLWEI_GetWei}, 0);
    chk(bus.DISWEIPEC_RdyWei == '0, {tag, "_rdy"}, bus.DISWEIPEC_RdyWei, 0);
    chk(bus.GBFWEI_AddrRd == '0 && bus.GBFFLGWEI_AddrRd == '0, {tag, "_addr"},
        {bus.GBFWEI_AddrRd, bus.GBFFLGWEI_AddrRd}, 0);
  endtask

  task automatic resetMid();
    bit saw;
    int start;
    saw = 1'b0;
    start = getPulses;
    bus.CFG_Dense = 1'b1;
    bus.CTRLWEI_PlsFetch = 1'b1;
    @(negedge clk);
    bus.CTRLWEI_PlsFetch = 1'b0;
    for (int c = 0; c < 100 && !saw; c++) begin
      @(negedge clk);
      saw = bus.GBFWEI_EnRd;
    end
    chk(saw, "reached_dat", saw, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkIdle("rst_mid");
    q.delete();
    mwa = 0;
    mfa = 0;
    totalWa = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk(getPulses == start, "no_getwei_after_abort", getPulses - start, 0);
  endtask

  initial begin
    bus.CTRLWEI_PlsFetch = 1'b0;
    bus.CFG_Dense = 1'b0;
    repeat (3) @(negedge clk);
    chkIdle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chkIdle("post_reset");
    fetch(1'b0, 2);
    chk(mwa == 2 && mfa == 2, "ff_case_addresses", {mwa[15:0], mfa[15:0]}, 32'h0002_0002);
    fetch(1'b0, 1);
    fetch(1'b0, 3);
    fetch(1'b1, 0);
    fetch(1'b0, 0);
    valRand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(1'b0, 0);
      fetch(1'b0, 3);
      fetch(1'b1, 0);
    end
    valRand = 1'b0;
    resetMid();
    fetch(1'b0, 2);
    valRand = 1'b1;
    while (totalWa < DEPTH + 80) fetch($urandom_range(3) != 0, 0);
    valRand = 1'b0;
    fetch(1'b0, 3);
    repeat (5) @(negedge clk);
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
